// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   INSTRBITWIDTH    : width of one fetched instruction word.
//   DEF_ADDRBITWIDTH : default address width; also the width of the address
//                      field kept alongside each buffered instruction.
//   fetch_state_t    : RUN (presenting instructions) / WAIT_BRANCH (holding
//                      output until an unresolved branch resolves).
//   fetch_entry_t    : one FIFO entry, instruction plus its word address.
package instruction_fetch_queue_pkg;

  localparam int INSTRBITWIDTH    = 16;
  localparam int DEF_ADDRBITWIDTH = 16;

  typedef enum logic [0:0] {
    RUN         = 1'b0,
    WAIT_BRANCH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTRBITWIDTH-1:0]    instr;
    logic [DEF_ADDRBITWIDTH-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory, the decoder and
// the branch unit.
//   master : the fetch queue (drives memory requests and decoder outputs).
//   slave  : the environment (memory, decoder, branch unit).
interface instruction_fetch_queue_if
  import instruction_fetch_queue_pkg::*;
#(
  parameter int ADDRBITWIDTH = DEF_ADDRBITWIDTH
);
  logic                     InstMemReqValid;
  logic                     InstMemReqReady;
  logic [ADDRBITWIDTH-1:0]  InstMemReqAddr;
  logic                     InstMemRespValid;
  logic [INSTRBITWIDTH-1:0] InstMemRespData;
  logic [INSTRBITWIDTH-1:0] InstructionOut;
  logic                     InstructionOutValid;
  logic [ADDRBITWIDTH-1:0]  InstructionOutPCPlusOne;
  logic                     IssueReady;
  logic                     BranchStall;
  logic                     BranchResolveValid;
  logic                     BranchTaken;
  logic [ADDRBITWIDTH-1:0]  BranchTarget;

  modport master (
    output InstMemReqValid, InstMemReqAddr,
    output InstructionOut, InstructionOutValid, InstructionOutPCPlusOne,
    input  InstMemReqReady, InstMemRespValid, InstMemRespData,
    input  IssueReady, BranchStall, BranchResolveValid, BranchTaken, BranchTarget
  );

  modport slave (
    input  InstMemReqValid, InstMemReqAddr,
    input  InstructionOut, InstructionOutValid, InstructionOutPCPlusOne,
    output InstMemReqReady, InstMemRespValid, InstMemRespData,
    output IssueReady, BranchStall, BranchResolveValid, BranchTaken, BranchTarget
  );
endinterface

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// Synchronous FIFO for fetched instructions, plus its overflow checker.
//   clk, rst     : clock, synchronous active-high reset.
//   push_i/data  : write one entry (ignored while flush_i is high).
//   pop_i        : drop the head entry (ignored when empty).
//   flush_i      : clear all entries.
//   head_o       : head entry, read straight from the storage registers.
//   count_o      : number of valid entries (0..DEPTH).
module instruction_fetch_queue_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against flush and empty.
  always_comb begin
    do_push_s = push_i && !flush_i;
    do_pop_s  = pop_i && (count_q != {CW{1'b0}});
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  instruction_fetch_queue_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_i),
    .pop_i   (pop_i),
    .flush_i (flush_i),
    .count_i (count_q)
  );
endmodule

// Overflow checker: the fetch credit scheme must never push into a full FIFO
// unless the head is popped in the same cycle.
module instruction_fetch_queue_fifo_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push_i,
  input logic          pop_i,
  input logic          flush_i,
  input logic [CW-1:0] count_i
);
  no_overflow_a : assert property (@(posedge clk) disable iff (rst)
    !(push_i && !flush_i && !pop_i && (count_i == CW'(DEPTH))));
endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the PC, issues in-order instruction-memory reads, buffers
// responses and presents one instruction (with its PC+1) per cycle to the
// decoder. Holds output while a decoded branch is unresolved and flushes on a
// taken redirect.
//   clk, rst : clock, synchronous active-high reset.
//   bus      : instruction_fetch_queue_if.master (memory, decoder, branch unit).
//   StallCycleCount, FlushCount : only when IFQ_PERF_COUNTER_EN is defined;
//              saturating counts of WAIT_BRANCH cycles and taken flushes.
// ADDRBITWIDTH must not exceed DEF_ADDRBITWIDTH (entry address field width).
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int                      ADDRBITWIDTH = DEF_ADDRBITWIDTH,
  parameter int                      QUEUEDEPTH   = 4,
  parameter logic [ADDRBITWIDTH-1:0] RESETVECTOR  = {ADDRBITWIDTH{1'b0}}
) (
  input  logic        clk,
  input  logic        rst,
  instruction_fetch_queue_if.master bus
`ifdef IFQ_PERF_COUNTER_EN
  ,
  output logic [15:0] StallCycleCount,
  output logic [15:0] FlushCount
`endif
);
  localparam int CW = $clog2(QUEUEDEPTH) + 1;
  // Stale responses can pile up across back-to-back flushes; give headroom.
  localparam int DW = CW + 4;
  localparam logic [ADDRBITWIDTH-1:0] ONE_A = {{(ADDRBITWIDTH-1){1'b0}}, 1'b1};

  fetch_state_t            state_q, state_d;
  logic [ADDRBITWIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]           outstanding_q, outstanding_d;
  logic [DW-1:0]           drop_q, drop_d;
  logic [CW-1:0]           count_s;
  fetch_entry_t            head_s;
  fetch_entry_t            push_entry_s;
  logic                    flush_s, out_valid_s, pop_s, req_valid_s, req_fire_s;
  logic                    resp_live_s, push_s;
  logic [ADDRBITWIDTH-1:0] resp_addr_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state and handshake decode.
  always_comb begin
    state_d     = state_q;
    flush_s     = 1'b0;
    out_valid_s = 1'b0;
    case (state_q)
      RUN: begin
        out_valid_s = !rst && (count_s != {CW{1'b0}});
        if (out_valid_s && bus.IssueReady && bus.BranchStall) state_d = WAIT_BRANCH;
        else                                                  state_d = RUN;
      end
      WAIT_BRANCH: begin
        if (bus.BranchResolveValid) begin
          flush_s = bus.BranchTaken;
          state_d = RUN;
        end else begin
          state_d = WAIT_BRANCH;
        end
      end
      default: state_d = RUN;
    endcase
    pop_s       = out_valid_s && bus.IssueReady;
    // Credit: every buffered or in-flight (non-stale) fetch owns a FIFO slot.
    req_valid_s = !rst && !flush_s &&
                  (({1'b0, count_s} + {1'b0, outstanding_q}) < (CW+1)'(QUEUEDEPTH));
    req_fire_s  = req_valid_s && bus.InstMemReqReady;
    resp_live_s = bus.InstMemRespValid && (drop_q == {DW{1'b0}});
    push_s      = resp_live_s && !flush_s;
    // Oldest live in-flight request sits outstanding words behind the PC.
    resp_addr_s = pc_q - ADDRBITWIDTH'(outstanding_q);
    push_entry_s.instr = bus.InstMemRespData;
    push_entry_s.addr  = DEF_ADDRBITWIDTH'(resp_addr_s);
  end

  // PC, in-flight and stale-response bookkeeping next state.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (flush_s) begin
      pc_d          = bus.BranchTarget;
      outstanding_d = {CW{1'b0}};
      // Everything still in flight becomes stale; a response landing now is one of them.
      drop_d        = drop_q + DW'(outstanding_q) - DW'(bus.InstMemRespValid);
    end else begin
      if (req_fire_s) pc_d = pc_q + ONE_A;
      else            pc_d = pc_q;
      outstanding_d = outstanding_q + CW'(req_fire_s) - CW'(resp_live_s);
      if (bus.InstMemRespValid && (drop_q != {DW{1'b0}})) drop_d = drop_q - {{(DW-1){1'b0}}, 1'b1};
      else                                                drop_d = drop_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESETVECTOR;
      outstanding_q <= {CW{1'b0}};
      drop_q        <= {DW{1'b0}};
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  instruction_fetch_queue_fetch_fifo #(
    .DEPTH (QUEUEDEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .flush_i     (flush_s),
    .head_o      (head_s),
    .count_o     (count_s)
  );

  assign bus.InstMemReqValid         = req_valid_s;
  assign bus.InstMemReqAddr          = pc_q;
  assign bus.InstructionOutValid     = out_valid_s;
  assign bus.InstructionOut          = out_valid_s ? head_s.instr : {INSTRBITWIDTH{1'b0}};
  assign bus.InstructionOutPCPlusOne = out_valid_s ? (ADDRBITWIDTH'(head_s.addr) + ONE_A)
                                                   : {ADDRBITWIDTH{1'b0}};

`ifdef IFQ_PERF_COUNTER_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating stall-cycle and flush counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if ((state_q == WAIT_BRANCH) && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'h0001;
      if (flush_s && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'h0001;
    end
  end

  assign StallCycleCount = stall_cnt_q;
  assign FlushCount      = flush_cnt_q;
`endif
endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;
  localparam int          AW    = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RV    = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_queue_if #(.ADDRBITWIDTH(AW)) bus ();
`ifdef IFQ_PERF_COUNTER_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  instruction_fetch_queue #(
    .ADDRBITWIDTH (AW),
    .QUEUEDEPTH   (DEPTH),
    .RESETVECTOR  (RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IFQ_PERF_COUNTER_EN
    ,
    .StallCycleCount (stall_cnt),
    .FlushCount      (flush_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: expected FIFO contents, fetch stream and branch hold.
  logic [15:0] m_fifo_instr[$];
  logic [15:0] m_fifo_addr[$];
  logic [15:0] m_infl[$];      // addresses requested, response not yet seen
  int          m_stale;        // oldest m_stale entries of m_infl belong to a flushed path
  logic [15:0] m_pc;
  bit          m_wait;
  int          m_stallc, m_flushc;

  // Instruction memory environment: in-order, latency >= 1.
  logic [15:0] mem_addr[$];
  int          mem_due[$];

  int p_issue, p_stall, p_resolve, p_taken, p_ready, p_resp, lat_max;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    logic [31:0] t;
    t = {16'h0000, a} * 32'h0000_9E37;
    return t[15:0] ^ 16'hA123 ^ {a[7:0], a[15:8]};
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  function automatic logic [15:0] pick_target();
    case ($urandom_range(3, 0))
      0:       return 16'h0040;
      1:       return 16'hFFFE;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic knobs(input int iss, input int stl, input int res, input int tak,
                       input int rdy, input int rsp, input int lat);
    p_issue = iss; p_stall = stl; p_resolve = res; p_taken = tak;
    p_ready = rdy; p_resp = rsp; lat_max = lat;
  endtask

  task automatic model_reset();
    m_fifo_instr.delete(); m_fifo_addr.delete(); m_infl.delete();
    mem_addr.delete(); mem_due.delete();
    m_stale = 0; m_pc = RV; m_wait = 1'b0; m_stallc = 0; m_flushc = 0;
  endtask

  task automatic run_cycle(input bit do_rst);
    bit          resp, flush, exp_rv, exp_ov, pop;
    int          live;
    logic [15:0] a, exp_instr, exp_pcp1;
    @(negedge clk);
    cyc++;
    resp = 1'b0;
    if (do_rst) begin
      rst = 1'b1;
      bus.IssueReady = 1'b0; bus.BranchStall = 1'b0; bus.BranchResolveValid = 1'b0;
      bus.BranchTaken = 1'b0; bus.BranchTarget = 16'h0000; bus.InstMemReqReady = 1'b0;
      bus.InstMemRespValid = 1'b0; bus.InstMemRespData = 16'h0000;
      #1;
      model_reset();
      return;
    end
    rst = 1'b0;
    bus.IssueReady         = pct(p_issue);
    bus.BranchStall        = pct(p_stall);
    bus.BranchResolveValid = pct(p_resolve);
    bus.BranchTaken        = pct(p_taken);
    bus.BranchTarget       = pick_target();
    bus.InstMemReqReady    = pct(p_ready);
    resp = (mem_addr.size() > 0) && (mem_due[0] <= cyc) && pct(p_resp);
    bus.InstMemRespValid = resp;
    bus.InstMemRespData  = resp ? instr_of(mem_addr[0]) : 16'h0000;
    #1;
    flush  = m_wait && bus.BranchResolveValid && bus.BranchTaken;
    live   = m_infl.size() - m_stale;
    exp_rv = ((m_fifo_instr.size() + live) < DEPTH) && !flush;
    exp_ov = (m_fifo_instr.size() > 0) && !m_wait;
    exp_instr = exp_ov ? m_fifo_instr[0] : 16'h0000;
    exp_pcp1  = exp_ov ? (m_fifo_addr[0] + 16'h0001) : 16'h0000;
    check_eq("req_valid", 16'(bus.InstMemReqValid), 16'(exp_rv));
    check_eq("req_addr", bus.InstMemReqAddr, m_pc);
    check_eq("out_valid", 16'(bus.InstructionOutValid), 16'(exp_ov));
    check_eq("out_instr", bus.InstructionOut, exp_instr);
    check_eq("out_pcp1", bus.InstructionOutPCPlusOne, exp_pcp1);
`ifdef IFQ_PERF_COUNTER_EN
    check_eq("stall_cnt", stall_cnt, 16'(m_stallc));
    check_eq("flush_cnt", flush_cnt, 16'(m_flushc));
`endif
    // Memory side follows what the DUT actually drives.
    if (resp) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    if (bus.InstMemReqValid && bus.InstMemReqReady) begin
      mem_addr.push_back(bus.InstMemReqAddr);
      mem_due.push_back(cyc + 1 + int'($urandom_range(lat_max, 0)));
    end
    // Reference model advances on its own expectations.
    pop = exp_ov && bus.IssueReady;
    if (pop) begin
      void'(m_fifo_instr.pop_front());
      void'(m_fifo_addr.pop_front());
    end
    if (resp && m_infl.size() > 0) begin
      a = m_infl.pop_front();
      if (m_stale > 0) m_stale--;
      else if (!flush) begin
        m_fifo_instr.push_back(instr_of(a));
        m_fifo_addr.push_back(a);
      end
    end
    if (exp_rv && bus.InstMemReqReady) begin
      m_infl.push_back(m_pc);
      m_pc = m_pc + 16'h0001;
    end
    if (m_wait && m_stallc < 65535) m_stallc++;
    if (flush) begin
      m_fifo_instr.delete();
      m_fifo_addr.delete();
      m_stale = m_infl.size();
      m_pc    = bus.BranchTarget;
      m_wait  = 1'b0;
      if (m_flushc < 65535) m_flushc++;
    end else if (m_wait && bus.BranchResolveValid) begin
      m_wait = 1'b0;
    end else if (!m_wait && pop && bus.BranchStall) begin
      m_wait = 1'b1;
    end
  endtask

  initial begin
    bus.IssueReady = 1'b0; bus.BranchStall = 1'b0; bus.BranchResolveValid = 1'b0;
    bus.BranchTaken = 1'b0; bus.BranchTarget = 16'h0000; bus.InstMemReqReady = 1'b0;
    bus.InstMemRespValid = 1'b0; bus.InstMemRespData = 16'h0000;
    knobs(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) run_cycle(1'b1);

    // Streaming with a 1-cycle memory and an always-ready decoder.
    knobs(100, 0, 0, 0, 100, 100, 0);
    repeat (20) run_cycle(1'b0);

    // Decoder back-pressure: credit limit, then trickle pops.
    knobs(0, 0, 0, 0, 100, 100, 0);
    repeat (10) run_cycle(1'b0);
    knobs(10, 0, 0, 0, 100, 100, 0);
    repeat (30) run_cycle(1'b0);

    // Branch hold resolved not-taken.
    knobs(100, 100, 0, 0, 100, 100, 0);
    repeat (8) run_cycle(1'b0);
    knobs(100, 0, 100, 0, 100, 100, 0);
    repeat (4) run_cycle(1'b0);

    // Branch hold with slow memory, resolved taken (stale responses in flight).
    knobs(100, 100, 0, 0, 100, 100, 3);
    repeat (4) run_cycle(1'b0);
    knobs(100, 0, 100, 100, 100, 100, 3);
    repeat (12) run_cycle(1'b0);

    // Random mix, including flushes to targets near the top of the address space.
    for (int k = 0; k < 40; k++) begin
      knobs(int'($urandom_range(100, 0)), int'($urandom_range(60, 0)), int'($urandom_range(40, 0)),
            int'($urandom_range(100, 0)), int'($urandom_range(100, 20)), int'($urandom_range(100, 30)),
            int'($urandom_range(3, 0)));
      repeat (80) run_cycle(1'b0);
    end

    // Reset while holding a branch with a full FIFO.
    knobs(100, 100, 0, 0, 100, 100, 0);
    repeat (15) run_cycle(1'b0);
    run_cycle(1'b1);
    knobs(100, 0, 0, 0, 100, 100, 0);
    repeat (10) run_cycle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
